// File: rtl/quad_decoder_if.sv
// Steering quadrature decoder bus: raw {B,A} input and clear strobes in,
// position count, step pulse, direction and sticky error out.
interface quad_decoder_if #(
    parameter int POS_WIDTH = 8
);
    logic [1:0]           quad_in;
    logic                 clr;
    logic                 err_clr;
    logic [POS_WIDTH-1:0] position;
    logic                 step;
    logic                 dir;
    logic                 err;

    modport master (
        output quad_in, clr, err_clr,
        input  position, step, dir, err
    );

    modport slave (
        input  quad_in, clr, err_clr,
        output position, step, dir, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronise and glitch-filter {B,A}, decode Gray-order
// transitions into a wrapping position count with step/dir and a sticky error.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_INIT | nothing accepted since reset; next acceptance is loaded silently
// ST_RUN  | accepted state valid; acceptances decode into step/err
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int POS_WIDTH   = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    quad_decoder_if.slave bus
);

    localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [1:0]           r_sync [SYNC_STAGES];
    logic [SYNC_STAGES:0] r_vld;
    logic [1:0]           r_cand;
    logic [1:0]           r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_step;
    logic                 r_dir;
    logic                 r_err;

    logic [1:0]           w_sync;
    logic [1:0]           w_delta;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_vld;
    logic                 w_reload;
    logic                 w_pending;
    logic                 w_hit;
    logic                 w_accept;
    logic [POS_WIDTH-1:0] w_pos_nxt;
    logic                 w_step_nxt;
    logic                 w_dir_nxt;
    logic                 w_err_nxt;

    function automatic logic [1:0] gray_idx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    // r_vld marks which sync stages hold real samples rather than reset values
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 2'b00;
            end
            r_vld <= '0;
        end else begin
            r_sync[0] <= bus.quad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_vld <= {r_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_vld     = r_vld[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // The first real sample after reset counts as a fresh candidate
    assign w_reload  = (w_sync != r_cand) || !r_vld[SYNC_STAGES];
    assign w_pending = (w_sync != r_acc) || (r_state == ST_INIT);
    assign w_hit     = w_reload ? (FILTER_LEN == 1) : (w_cnt_inc == CNT_LAST);
    assign w_accept  = w_vld && w_pending && w_hit;
    assign w_delta   = gray_idx(w_sync) - gray_idx(r_acc);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cand <= 2'b00;
            r_cnt  <= '0;
            r_acc  <= 2'b00;
        end else begin
            if (w_reload) begin
                r_cand <= w_sync;
                r_cnt  <= '0;
            end else if (w_pending) begin
                r_cnt  <= w_cnt_inc;
            end else begin
                r_cnt  <= '0;
            end
            if (w_accept) begin
                r_acc <= w_sync;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_INIT;
            r_pos   <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_step  <= w_step_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Gray index delta: +1 is the forward (left) order, -1 reverse (right), 2 illegal
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        w_err_nxt   = r_err & ~bus.err_clr;
        case (r_state)
            ST_INIT: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    case (w_delta)
                        2'd1: begin
                            w_pos_nxt  = r_pos - POS_WIDTH'(1);
                            w_dir_nxt  = 1'b0;
                            w_step_nxt = 1'b1;
                        end
                        2'd3: begin
                            w_pos_nxt  = r_pos + POS_WIDTH'(1);
                            w_dir_nxt  = 1'b1;
                            w_step_nxt = 1'b1;
                        end
                        2'd2: begin
                            w_err_nxt  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (bus.clr) begin
            w_pos_nxt = '0;
        end
    end

    assign bus.position = r_pos;
    assign bus.step     = r_step;
    assign bus.dir      = r_dir;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random phase walks, all checked
// every cycle against a sample-history reference model.
module tb_quad_decoder;

    localparam int S  = 2;
    localparam int F  = 3;
    localparam int PW = 8;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    quad_decoder_if #(.POS_WIDTH(PW)) bus ();

    quad_decoder #(
        .SYNC_STAGES(S),
        .FILTER_LEN (F),
        .POS_WIDTH  (PW)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue models the synchroniser delay, then a run-length
    // of identical samples decides acceptance; direction comes from Gray index.
    int         gidx [4] = '{0, 1, 3, 2};
    logic [1:0] q [$];
    logic [1:0] m_v;
    logic [1:0] m_acc     = 2'b00;
    logic [1:0] run_val   = 2'b00;
    int         run_len   = 0;
    bit         m_init    = 0;
    int         m_pos     = 0;
    bit         m_step    = 0;
    bit         m_dir     = 0;
    bit         m_err     = 0;
    bit         m_illegal = 0;
    int         m_d;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q.delete();
            m_acc   = 2'b00;
            run_len = 0;
            m_init  = 0;
            m_pos   = 0;
            m_step  = 0;
            m_dir   = 0;
            m_err   = 0;
        end else begin
            m_step    = 0;
            m_illegal = 0;
            q.push_back(bus.quad_in);
            if (q.size() > S) begin
                m_v = q.pop_front();
                if (run_len > 0 && m_v == run_val) run_len++;
                else begin
                    run_val = m_v;
                    run_len = 1;
                end
                if (run_len == F && (!m_init || m_v != m_acc)) begin
                    if (!m_init) m_init = 1;
                    else begin
                        m_d = (gidx[m_v] - gidx[m_acc] + 4) % 4;
                        if (m_d == 1) begin
                            m_pos  = (m_pos + (1 << PW) - 1) % (1 << PW);
                            m_dir  = 0;
                            m_step = 1;
                        end else if (m_d == 3) begin
                            m_pos  = (m_pos + 1) % (1 << PW);
                            m_dir  = 1;
                            m_step = 1;
                        end else m_illegal = 1;
                    end
                    m_acc = m_v;
                end
            end
            if (m_illegal) m_err = 1;
            else if (bus.err_clr) m_err = 0;
            if (bus.clr) m_pos = 0;
        end
    end

    int n_steps = 0;

    always @(negedge CLK) begin
        if (RESET_N) begin
            check("step", 32'(bus.step), 32'(m_step));
            check("dir", 32'(bus.dir), 32'(m_dir));
            check("position", 32'(bus.position), 32'(m_pos));
            check("err", 32'(bus.err), 32'(m_err));
            if (bus.step) n_steps++;
        end
    end

    function automatic logic [1:0] right_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] left_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic do_reset(input logic [1:0] v);
        RESET_N     = 1'b0;
        bus.quad_in = v;
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    // Hold v for `hold` cycles; optional clears land on the acceptance edge
    task automatic phase(input logic [1:0] v, input int hold, input bit clr_acc, input bit eclr_acc);
        bus.quad_in = v;
        for (int i = 0; i < hold; i++) begin
            bus.clr     = clr_acc && (i == S + F - 1);
            bus.err_clr = eclr_acc && (i == S + F - 1);
            @(negedge CLK);
        end
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [1:0] p;
        bus.quad_in = 2'b00;
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
        @(negedge CLK);

        // Resting at a non-zero phase out of reset is absorbed silently
        do_reset(2'b11);
        check("t1_steps", 32'(n_steps), 32'd0);
        check("t1_pos", 32'(bus.position), 32'd0);
        check("t1_err", 32'(bus.err), 32'd0);

        do_reset(2'b00);
        base = n_steps;
        p = 2'b00;
        repeat (4) begin
            p = right_of(p);
            phase(p, 8, 0, 0);
        end
        check("t2_steps", 32'(n_steps - base), 32'd4);
        check("t2_pos", 32'(bus.position), 32'd4);
        check("t2_dir", 32'(bus.dir), 32'd1);

        do_reset(2'b00);
        base = n_steps;
        p = 2'b00;
        repeat (8) begin
            p = left_of(p);
            phase(p, 8, 0, 0);
        end
        check("t3_steps", 32'(n_steps - base), 32'd8);
        check("t3_pos", 32'(bus.position), 32'hF8);
        check("t3_dir", 32'(bus.dir), 32'd0);

        base = n_steps;
        phase(2'b01, 2, 0, 0);
        phase(2'b00, 10, 0, 0);
        check("t4_short_steps", 32'(n_steps - base), 32'd0);
        check("t4_short_pos", 32'(bus.position), 32'hF8);
        phase(2'b01, 3, 0, 0);
        phase(2'b00, 10, 0, 0);
        check("t4_long_steps", 32'(n_steps - base), 32'd2);
        check("t4_long_pos", 32'(bus.position), 32'hF8);

        base = n_steps;
        phase(2'b11, 8, 0, 0);
        check("t5_err", 32'(bus.err), 32'd1);
        check("t5_pos", 32'(bus.position), 32'hF8);
        check("t5_steps", 32'(n_steps - base), 32'd0);
        phase(2'b00, 8, 0, 1);
        check("t5_set_wins", 32'(bus.err), 32'd1);
        bus.err_clr = 1'b1;
        @(negedge CLK);
        bus.err_clr = 1'b0;
        check("t5_err_clr", 32'(bus.err), 32'd0);

        do_reset(2'b00);
        p = 2'b00;
        repeat (127) begin
            p = right_of(p);
            phase(p, 4, 0, 0);
        end
        repeat (4) @(negedge CLK);
        check("t6_pos_7f", 32'(bus.position), 32'h7F);
        p = right_of(p);
        bus.quad_in = p;
        repeat (S + F - 1) @(negedge CLK);
        bus.clr = 1'b1;
        @(negedge CLK);
        bus.clr = 1'b0;
        check("t6_clr_step", 32'(bus.step), 32'd1);
        check("t6_clr_dir", 32'(bus.dir), 32'd1);
        check("t6_clr_pos", 32'(bus.position), 32'd0);
        repeat (3) @(negedge CLK);
        p = right_of(p);
        phase(p, 8, 0, 0);
        check("t6_after_clr", 32'(bus.position), 32'd1);

        do_reset(2'b00);
        p = 2'b00;
        repeat (128) begin
            p = right_of(p);
            phase(p, 4, 0, 0);
        end
        repeat (4) @(negedge CLK);
        check("t6_wrap", 32'(bus.position), 32'h80);
        p = right_of(p);
        bus.quad_in = p;
        repeat (S + F - 1) @(negedge CLK);
        #7 RESET_N = 1'b0;
        #1;
        check("t6_rst_pos", 32'(bus.position), 32'd0);
        check("t6_rst_dir", 32'(bus.dir), 32'd0);
        check("t6_rst_step", 32'(bus.step), 32'd0);
        check("t6_rst_err", 32'(bus.err), 32'd0);

        // Random walk: mostly legal neighbours, some illegal/repeat phases and glitches
        do_reset(2'($urandom_range(0, 3)));
        p = bus.quad_in;
        repeat (300) begin
            int sel;
            int hold;
            sel  = $urandom_range(0, 9);
            hold = $urandom_range(1, 8);
            if (sel < 4) p = right_of(p);
            else if (sel < 8) p = left_of(p);
            else p = 2'($urandom_range(0, 3));
            bus.quad_in = p;
            for (int i = 0; i < hold; i++) begin
                bus.clr     = ($urandom_range(0, 15) == 0);
                bus.err_clr = ($urandom_range(0, 7) == 0);
                @(negedge CLK);
            end
            bus.clr     = 1'b0;
            bus.err_clr = 1'b0;
        end
        repeat (10) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
